// File: rtl/bnn_pkg.sv
// Shared constants and types for the time-multiplexed 8-8-4 BNN sequencer.
package bnn_pkg;

    localparam int NUM_NEURONS = 20;
    localparam int L1_N        = 8;
    localparam int L2_N        = 8;
    localparam int L3_N        = 4;

    localparam int W_WIDTH     = 8;
    localparam int T_WIDTH     = 4;
    localparam int IDX_WIDTH   = 5;

    localparam logic [IDX_WIDTH-1:0] L1_BASE  = 5'd0;
    localparam logic [IDX_WIDTH-1:0] L2_BASE  = 5'd8;
    localparam logic [IDX_WIDTH-1:0] L3_BASE  = 5'd16;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = 5'd19;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/bnn_neuron_unit.sv
// Single binary neuron: XNOR operand against weight, popcount, fire when count >= threshold.
module bnn_neuron_unit
    import bnn_pkg::*;
(
    input  logic [W_WIDTH-1:0] operand,
    input  logic [W_WIDTH-1:0] weight,
    input  logic [T_WIDTH-1:0] thresh,
    output logic               fire
);

    logic [W_WIDTH-1:0] match;
    logic [3:0]         pop;

    always_comb begin
        match = ~(operand ^ weight);
        pop   = '0;
        for (int i = 0; i < W_WIDTH; i++) begin
            pop = pop + {3'b000, match[i]};
        end
    end

    // Thresholds 9..15 exceed the maximum count of 8 and therefore never fire.
    assign fire = (pop >= thresh);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Walks one shared neuron unit over all 20 neurons of the 8-8-4 BNN, layer by layer,
// reading weight/threshold from the config file and yielding to the loader via cfg_busy.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; cfg_addr parked at 0
//   ST_L1   | evaluating neurons 0..7 on the latched input vector
//   ST_L2   | evaluating neurons 8..15 on l1_vec
//   ST_L3   | evaluating neurons 16..19 on l2_vec
//   ST_DONE | one-cycle done pulse; result/hidden already loaded
module bnn_layer_sequencer
    import bnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [7:0]           in_vec,
    input  logic                 cfg_busy,
    output logic [IDX_WIDTH-1:0] cfg_addr,
    input  logic [W_WIDTH-1:0]   cfg_weight,
    input  logic [T_WIDTH-1:0]   cfg_thresh,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           result,
    output logic [3:0]           hidden
);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]             in_vec_q, in_vec_d;
    logic [7:0]             l1_vec_q, l1_vec_d;
    logic [7:0]             l2_vec_q, l2_vec_d;
    logic [3:0]             l3_vec_q, l3_vec_d;
    logic [3:0]             result_q, result_d;
    logic [3:0]             hidden_q, hidden_d;

    logic [7:0]             operand;
    logic                   fire;
    logic                   adv;
    logic                   eval_st;

    assign adv     = ena && !cfg_busy;
    assign eval_st = (state_q == ST_L1) || (state_q == ST_L2) || (state_q == ST_L3);

    always_comb begin
        case (state_q)
            ST_L1:   operand = in_vec_q;
            ST_L2:   operand = l1_vec_q;
            ST_L3:   operand = l2_vec_q;
            default: operand = '0;
        endcase
    end

    bnn_neuron_unit u_neuron (
        .operand (operand),
        .weight  (cfg_weight),
        .thresh  (cfg_thresh),
        .fire    (fire)
    );

    // Layer bases are multiples of the layer width, so the low idx bits are the bit offset.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_vec_d = in_vec_q;
        l1_vec_d = l1_vec_q;
        l2_vec_d = l2_vec_q;
        l3_vec_d = l3_vec_q;
        result_d = result_q;
        hidden_d = hidden_q;

        case (state_q)
            ST_IDLE: begin
                if (ena && start && !cfg_busy) begin
                    in_vec_d = in_vec;
                    idx_d    = L1_BASE;
                    state_d  = ST_L1;
                end
            end
            ST_L1: begin
                if (adv) begin
                    l1_vec_d[idx_q[2:0]] = fire;
                    idx_d = idx_q + 5'd1;
                    if (idx_q == L2_BASE - 5'd1) begin
                        state_d = ST_L2;
                    end
                end
            end
            ST_L2: begin
                if (adv) begin
                    l2_vec_d[idx_q[2:0]] = fire;
                    idx_d = idx_q + 5'd1;
                    if (idx_q == L3_BASE - 5'd1) begin
                        state_d = ST_L3;
                    end
                end
            end
            ST_L3: begin
                if (adv) begin
                    l3_vec_d[idx_q[1:0]] = fire;
                    idx_d = idx_q + 5'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d  = ST_DONE;
                        idx_d    = '0;
                        result_d = l3_vec_d;
                        hidden_d = l2_vec_q[7:4];
                    end
                end
            end
            ST_DONE: begin
                if (ena) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            in_vec_q <= '0;
            l1_vec_q <= '0;
            l2_vec_q <= '0;
            l3_vec_q <= '0;
            result_q <= '0;
            hidden_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            in_vec_q <= in_vec_d;
            l1_vec_q <= l1_vec_d;
            l2_vec_q <= l2_vec_d;
            l3_vec_q <= l3_vec_d;
            result_q <= result_d;
            hidden_q <= hidden_d;
        end
    end

    assign cfg_addr = eval_st ? idx_q : '0;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign hidden   = hidden_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed and randomized checks of the BNN layer sequencer against a behavioural config file.
module tb_bnn_layer_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] in_vec;
    logic       cfg_busy;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_weight;
    logic [3:0] cfg_thresh;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [3:0] hidden;

    logic [7:0] w_mem [0:19];
    logic [3:0] t_mem [0:19];

    int n_vec = 0;
    int n_err = 0;

    assign cfg_weight = (cfg_addr < 5'd20) ? w_mem[cfg_addr] : 8'h00;
    assign cfg_thresh = (cfg_addr < 5'd20) ? t_mem[cfg_addr] : 4'h0;

    bnn_layer_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .in_vec     (in_vec),
        .cfg_busy   (cfg_busy),
        .cfg_addr   (cfg_addr),
        .cfg_weight (cfg_weight),
        .cfg_thresh (cfg_thresh),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .hidden     (hidden)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] w, input logic [3:0] t);
        for (int i = 0; i < 20; i++) begin
            w_mem[i] = w;
            t_mem[i] = t;
        end
    endtask

    // Leaves the bench in the done cycle (or after the cycle budget expires).
    task automatic run_inf(input logic [7:0] iv, output int lat);
        in_vec = iv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_on_accept", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    function automatic int pc(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // Returns {hidden, result} for the current config memory contents.
    function automatic logic [7:0] ref_out(input logic [7:0] iv);
        logic [7:0] l1, l2;
        logic [3:0] l3;
        for (int n = 0; n < 8; n++) l1[n] = (pc(~(iv ^ w_mem[n])) >= int'(t_mem[n]));
        for (int n = 0; n < 8; n++) l2[n] = (pc(~(l1 ^ w_mem[8+n])) >= int'(t_mem[8+n]));
        for (int n = 0; n < 4; n++) l3[n] = (pc(~(l2 ^ w_mem[16+n])) >= int'(t_mem[16+n]));
        return {l2[7:4], l3};
    endfunction

    initial begin
        int lat;
        int cnt;
        int n_done;
        bit stalled;
        logic [7:0] exp_o;

        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        in_vec   = 8'h00;
        cfg_busy = 1'b0;
        fill(8'h00, 4'd4);
        #12;
        chk("rst_busy",     {31'b0, busy},  32'd0);
        chk("rst_done",     {31'b0, done},  32'd0);
        chk("rst_result",   {28'b0, result}, 32'd0);
        chk("rst_hidden",   {28'b0, hidden}, 32'd0);
        chk("rst_cfg_addr", {27'b0, cfg_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // start blocked while the loader owns the config file
        cfg_busy = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cfg_busy = 1'b0;
        chk("start_blocked_cfg_busy", {31'b0, busy}, 32'd0);

        // scenario 1
        run_inf(8'h00, lat);
        chk("s1_latency", lat, 32'd20);
        chk("s1_result", {28'b0, result}, 32'hF);
        chk("s1_hidden", {28'b0, hidden}, 32'h0);
        chk("s1_l1_vec", {24'b0, dut.l1_vec_q}, 32'hFF);
        tick();
        chk("s1_done_width", {31'b0, done}, 32'd0);
        chk("s1_busy_drop", {31'b0, busy}, 32'd0);

        fill(8'h00, 4'd0);
        run_inf(8'hA5, lat);
        chk("th0_result", {28'b0, result}, 32'hF);
        chk("th0_hidden", {28'b0, hidden}, 32'hF);
        tick();

        fill(8'h00, 4'd9);
        run_inf(8'hA5, lat);
        chk("th9_result", {28'b0, result}, 32'h0);
        chk("th9_hidden", {28'b0, hidden}, 32'h0);
        tick();

        // stall of 3 cycles at idx 10
        fill(8'h00, 4'd4);
        in_vec = 8'h00;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 0;
        stalled = 1'b0;
        while (!done && lat < 100) begin
            if (cfg_addr == 5'd10 && !stalled) begin
                cfg_busy = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    lat++;
                    chk("stall_addr_hold", {27'b0, cfg_addr}, 32'd10);
                end
                cfg_busy = 1'b0;
                stalled  = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        chk("stall_latency", lat, 32'd23);
        chk("stall_result", {28'b0, result}, 32'hF);
        tick();

        // start pulses while busy and during done are ignored
        in_vec = 8'h00;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        while (!done && lat < 100) begin
            start = (lat == 4 || lat == 11) ? 1'b1 : 1'b0;
            tick();
            lat++;
        end
        start = 1'b0;
        chk("ign_latency", lat, 32'd20);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_in_done_busy", {31'b0, busy}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (done) n_done++;
        end
        chk("ign_no_extra_done", n_done, 32'd0);
        run_inf(8'h00, lat);
        chk("second_run_latency", lat, 32'd20);
        chk("second_run_result", {28'b0, result}, 32'hF);
        tick();

        // reset in the middle of layer 2
        in_vec = 8'h00;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (cfg_addr != 5'd12 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("reach_idx12", {27'b0, cfg_addr}, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {31'b0, busy},   32'd0);
        chk("midrst_result", {28'b0, result}, 32'h0);
        chk("midrst_done",   {31'b0, done},   32'd0);
        #3;
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 32'd0);
        run_inf(8'h00, lat);
        chk("post_rst_latency", lat, 32'd20);
        chk("post_rst_result", {28'b0, result}, 32'hF);
        tick();

        // randomized networks against the reference model
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 20; i++) begin
                w_mem[i] = 8'($urandom_range(0, 255));
                t_mem[i] = 4'($urandom_range(0, 10));
            end
            exp_o = ref_out(8'($urandom_range(0, 255)));
            exp_o = 8'h00;
            in_vec = 8'($urandom_range(0, 255));
            exp_o  = ref_out(in_vec);
            run_inf(in_vec, lat);
            chk("rnd_latency", lat, 32'd20);
            chk("rnd_result", {28'b0, result}, {28'b0, exp_o[3:0]});
            chk("rnd_hidden", {28'b0, hidden}, {28'b0, exp_o[7:4]});
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
